pq_client_adapter: RTL

Handshake front-end that drives the register-array priority queue's push/pop/status interface on behalf of streaming clients. Accepts push and pop requests on valid/ready channels and issues at most one queue operation per cycle (push, pop or replace). Returns popped heads on a buffered response channel and supports a drain-to-empty flush. Sits between the scheduler logic and the queue instance.

---
 rtl/pq_pkg.sv | 22 ++
 rtl/pq_rsp_fifo.sv | 61 ++++++
 rtl/pq_client_adapter.sv | 119 +++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue client adapter: FSM states, queue
// operation encoding and the reserved empty-slot key.
package pq_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pq_state_e;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } pq_op_e;

    // Key value the queue uses to mark an unoccupied slot; never inserted.
    localparam logic [63:0] EMPTY_KEY = 64'd0;

    localparam logic [1:0] RSP_FIFO_FULL = 2'd2;

endpackage

// File: rtl/pq_rsp_fifo.sv
// Two-entry response FIFO for popped queue heads; entry 0 is always the
// head, so o_data comes straight from a register.
module pq_rsp_fifo #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] mem0_r;
    logic [DATA_WIDTH-1:0] mem1_r;
    logic [1:0]            cnt_r;
    logic                  drain_s;

    assign drain_s = (cnt_r != 2'd0) && i_ready;
    assign o_valid = (cnt_r != 2'd0);
    assign o_data  = mem0_r;
    assign o_cnt   = cnt_r;

    // Storage and occupancy update; simultaneous push and drain keep the count.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            mem0_r <= {DATA_WIDTH{1'b0}};
            mem1_r <= {DATA_WIDTH{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            case ({push, drain_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        mem0_r <= push_data;
                    end else begin
                        mem1_r <= push_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    mem0_r <= mem1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        mem0_r <= push_data;
                    end else begin
                        mem0_r <= mem1_r;
                        mem1_r <= push_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/pq_client_adapter.sv
// Valid/ready front-end for the register-array priority queue: one push, pop
// or replace per cycle, buffered pop responses and drain-to-empty flush.
module pq_client_adapter
    import pq_pkg::*;
#(
    parameter int QUEUE_SIZE = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ENQ_ENA    = 1
) (
    input  logic                            i_CLK,
    input  logic                            i_RSTn,
    input  logic                            i_push_valid,
    input  logic [DATA_WIDTH-1:0]           i_push_data,
    output logic                            o_push_ready,
    input  logic                            i_pop_valid,
    output logic                            o_pop_ready,
    output logic                            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_data,
    input  logic                            i_rsp_ready,
    input  logic                            i_flush,
    output logic                            o_flush_done,
    output logic                            o_zero_drop,
    output logic [$clog2(QUEUE_SIZE):0]     o_level,
    output logic                            o_pq_wrt,
    output logic                            o_pq_read,
    output logic [DATA_WIDTH-1:0]           o_pq_data,
    input  logic                            i_pq_full,
    input  logic                            i_pq_empty,
    input  logic [DATA_WIDTH-1:0]           i_pq_data
);

    localparam int             LW      = $clog2(QUEUE_SIZE) + 1;
    localparam logic [LW-1:0]  LVL_MAX = LW'(QUEUE_SIZE);

    pq_state_e       state_r;
    pq_op_e          op_s;
    logic            push_ok_s;
    logic            zero_push_s;
    logic            can_pop_s;
    logic            flush_pop_s;
    logic            rsp_push_s;
    logic [1:0]      rsp_cnt_s;
    logic [LW-1:0]   level_r;

    assign push_ok_s   = i_push_valid && (i_push_data != DATA_WIDTH'(EMPTY_KEY));
    assign zero_push_s = i_push_valid && (i_push_data == DATA_WIDTH'(EMPTY_KEY));
    assign can_pop_s   = !i_pq_empty && (rsp_cnt_s != RSP_FIFO_FULL);

    // Same-cycle operation decode; replace wins so a full queue still accepts push+pop.
    always_comb begin
        op_s         = OP_NONE;
        flush_pop_s  = 1'b0;
        o_flush_done = 1'b0;
        o_zero_drop  = 1'b0;
        if (state_r == ST_RUN) begin
            if (push_ok_s && i_pop_valid && can_pop_s) begin
                op_s = OP_REPLACE;
            end else if (i_pop_valid && can_pop_s && !push_ok_s) begin
                op_s = OP_POP;
            end else if (push_ok_s && (ENQ_ENA != 0) && !i_pq_full) begin
                op_s = OP_PUSH;
            end else begin
                op_s = OP_NONE;
            end
            o_zero_drop = zero_push_s;
        end else begin
            flush_pop_s  = !i_pq_empty;
            o_flush_done = i_pq_empty;
        end
    end

    assign o_pq_wrt     = (op_s == OP_PUSH) || (op_s == OP_REPLACE);
    assign o_pq_read    = (op_s == OP_POP) || (op_s == OP_REPLACE) || flush_pop_s;
    assign o_pq_data    = o_pq_wrt ? i_push_data : DATA_WIDTH'(EMPTY_KEY);
    assign o_push_ready = o_pq_wrt || o_zero_drop;
    assign o_pop_ready  = (op_s == OP_POP) || (op_s == OP_REPLACE);
    assign rsp_push_s   = o_pop_ready;
    assign o_level      = level_r;

    // Run/flush state; a flush request while already flushing is ignored.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN:   state_r <= i_flush ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_r <= i_pq_empty ? ST_RUN : ST_FLUSH;
                default:  state_r <= ST_RUN;
            endcase
        end
    end

    // Shadow occupancy, saturating at both ends.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            level_r <= {LW{1'b0}};
        end else if (((op_s == OP_POP) || flush_pop_s) && (level_r != {LW{1'b0}})) begin
            level_r <= level_r - LW'(1);
        end else if ((op_s == OP_PUSH) && (level_r != LVL_MAX)) begin
            level_r <= level_r + LW'(1);
        end else begin
            level_r <= level_r;
        end
    end

    pq_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .push      (rsp_push_s),
        .push_data (i_pq_data),
        .o_valid   (o_rsp_valid),
        .o_data    (o_rsp_data),
        .i_ready   (i_rsp_ready),
        .o_cnt     (rsp_cnt_s)
    );

endmodule
